serial_parity_frame_ctrl: RTL and testbench

Frame sequencer for the serial parity path. Accepts parallel words on a valid/ready handshake and shifts each word out LSB-first, one bit per cycle. It tracks running parity of the shifted bits with a Mealy-style toggle accumulator and appends one parity bit per frame. The serial side has its own valid/ready handshake. A wrapping frame counter is exposed for status.

---
 rtl/serial_parity_frame_ctrl.sv | 123 ++++++++++++
 tb/tb_serial_parity_frame_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_parity_frame_ctrl.sv
// ============================================================================
// Module   : serial_parity_frame_ctrl
// Summary  : Serialises parallel words LSB-first and appends one parity bit
//            per frame. Define SERIAL_PARITY_ODD_EN to select odd parity.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_parity_frame_ctrl #(
  parameter int DATA_W      = 8,
  parameter int FRAME_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   ser_out,
  output logic                   ser_valid,
  input  logic                   ser_ready,
  output logic                   ser_last,
  output logic                   busy,
  output logic [FRAME_CNT_W-1:0] frame_count
);

  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

`ifdef SERIAL_PARITY_ODD_EN
  localparam logic PAR_ODD = 1'b1;
`else
  localparam logic PAR_ODD = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_t;

  state_t                 state_q;
  logic [DATA_W-1:0]      shreg_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   acc_q;
  logic [FRAME_CNT_W-1:0] frame_count_q;
  logic                   ser_out_q;
  logic                   ser_valid_q;
  logic                   ser_last_q;
  logic                   busy_q;
  logic                   load_d;

  // A new word is taken from IDLE, or in the accepted parity beat for a
  // back-to-back frame with no idle gap.
  assign in_ready = ~reset & ((state_q == ST_IDLE) ||
                              ((state_q == ST_PARITY) && ser_ready));
  assign load_d   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      shreg_q       <= '0;
      cnt_q         <= '0;
      acc_q         <= 1'b0;
      frame_count_q <= '0;
      ser_out_q     <= 1'b0;
      ser_valid_q   <= 1'b0;
      ser_last_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_SHIFT: begin
          if (ser_ready) begin
            acc_q   <= acc_q ^ shreg_q[0];
            shreg_q <= {1'b0, shreg_q[DATA_W-1:1]};
            cnt_q   <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
              state_q    <= ST_PARITY;
              ser_out_q  <= acc_q ^ shreg_q[0] ^ PAR_ODD;
              ser_last_q <= 1'b1;
            end else begin
              ser_out_q  <= shreg_q[1];
            end
          end
        end
        ST_PARITY: begin
          if (ser_ready) begin
            frame_count_q <= frame_count_q + FRAME_CNT_W'(1);
            ser_last_q    <= 1'b0;
            if (!in_valid) begin
              state_q     <= ST_IDLE;
              ser_out_q   <= 1'b0;
              ser_valid_q <= 1'b0;
              busy_q      <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase

      // Load overrides the PARITY/IDLE defaults above when a word is taken.
      if (load_d) begin
        state_q     <= ST_SHIFT;
        shreg_q     <= in_data;
        cnt_q       <= '0;
        acc_q       <= 1'b0;
        ser_out_q   <= in_data[0];
        ser_valid_q <= 1'b1;
        ser_last_q  <= 1'b0;
        busy_q      <= 1'b1;
      end
    end
  end

  assign ser_out     = ser_out_q   & ~reset;
  assign ser_valid   = ser_valid_q & ~reset;
  assign ser_last    = ser_last_q  & ~reset;
  assign busy        = busy_q      & ~reset;
  assign frame_count = frame_count_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_parity_frame_ctrl.sv
// ============================================================================
// Module   : tb_serial_parity_frame_ctrl
// Summary  : Directed self-checking bench for serial_parity_frame_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_parity_frame_ctrl;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       ser_out;
  logic       ser_valid;
  logic       ser_ready;
  logic       ser_last;
  logic       busy;
  logic [7:0] frame_count;

  logic       in_ready2;
  logic       ser_out2;
  logic       ser_valid2;
  logic       ser_last2;
  logic       busy2;
  logic [1:0] frame_count2;

  int checks;
  int errors;

  serial_parity_frame_ctrl #(.DATA_W(8), .FRAME_CNT_W(8)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .ser_out(ser_out), .ser_valid(ser_valid),
    .ser_ready(ser_ready), .ser_last(ser_last), .busy(busy),
    .frame_count(frame_count)
  );

  serial_parity_frame_ctrl #(.DATA_W(8), .FRAME_CNT_W(2)) u_dut_cnt2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .ser_out(ser_out2), .ser_valid(ser_valid2),
    .ser_ready(ser_ready), .ser_last(ser_last2), .busy(busy2),
    .frame_count(frame_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic exp_par(input logic [7:0] d);
`ifdef SERIAL_PARITY_ODD_EN
    return ~(^d);
`else
    return ^d;
`endif
  endfunction

  // Sends one frame from IDLE with ser_ready high, optionally stalling
  // stall_n cycles while bit stall_at is presented.
  task automatic send_frame(input logic [7:0] d, input int stall_at,
                            input int stall_n);
    int n;
    n = 0;
    check_val("idle_in_ready", in_ready, 1);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == stall_at) begin
        ser_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          check_val("stall_out", ser_out, d[i]);
          check_val("stall_valid", ser_valid, 1);
          n += busy;
          tick();
        end
        ser_ready = 1'b1;
      end
      check_val("bit", ser_out, d[i]);
      check_val("bit_valid", ser_valid, 1);
      check_val("bit_last", ser_last, 0);
      check_val("bit_in_ready", in_ready, 0);
      n += busy;
      tick();
    end
    check_val("parity", ser_out, exp_par(d));
    check_val("parity_last", ser_last, 1);
    n += busy;
    tick();
    check_val("end_busy", busy, 0);
    check_val("end_valid", ser_valid, 0);
    check_val("frame_len", n, 9 + stall_n);
  endtask

  initial begin
    logic [7:0] words [5];
    logic [1:0] cnt_exp [5];
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    ser_ready = 1'b1;

    // Reset state
    tick();
    tick();
    check_val("rst_in_ready", in_ready, 0);
    check_val("rst_valid", ser_valid, 0);
    check_val("rst_last", ser_last, 0);
    check_val("rst_out", ser_out, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_count", frame_count, 0);
    reset = 1'b0;
    #1;
    check_val("post_rst_in_ready", in_ready, 1);

    // 0xA5: bits 1,0,1,0,0,1,0,1, even parity 0
    send_frame(8'hA5, -1, 0);
    check_val("count_a5", frame_count, 1);
    check_val("par_a5_const", exp_par(8'hA5), 1'b0 ^ (exp_par(8'h00)));

    // 0x07: three ones
    send_frame(8'h07, -1, 0);
    check_val("count_07", frame_count, 2);

    // Back-to-back 0xFF then 0x01 with in_valid held
    in_valid = 1'b1;
    in_data  = 8'hFF;
    tick();
    for (int i = 0; i < 8; i++) begin
      check_val("b2b_a_bit", ser_out, 1);
      check_val("b2b_a_valid", ser_valid, 1);
      check_val("b2b_a_in_ready", in_ready, 0);
      tick();
    end
    check_val("b2b_a_par", ser_out, exp_par(8'hFF));
    check_val("b2b_a_last", ser_last, 1);
    check_val("b2b_a_in_ready_par", in_ready, 1);
    in_data = 8'h01;
    tick();
    in_valid = 1'b0;
    check_val("b2b_count", frame_count, 3);
    for (int i = 0; i < 8; i++) begin
      check_val("b2b_b_bit", ser_out, (i == 0) ? 1 : 0);
      check_val("b2b_b_valid", ser_valid, 1);
      check_val("b2b_b_last", ser_last, 0);
      tick();
    end
    check_val("b2b_b_par", ser_out, exp_par(8'h01));
    check_val("b2b_b_last_par", ser_last, 1);
    tick();
    check_val("b2b_end_busy", busy, 0);
    check_val("b2b_count2", frame_count, 4);

    // Backpressure: 3-cycle stall on bit 4 of 0x3C, frame takes 12 cycles
    send_frame(8'h3C, 4, 3);
    check_val("count_3c", frame_count, 5);

    // Reset at bit 5 of a frame
    in_valid = 1'b1;
    in_data  = 8'h5A;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check_val("mid_bit5", ser_out, 0);
    reset = 1'b1;
    #1;
    check_val("mid_rst_valid", ser_valid, 0);
    tick();
    reset = 1'b0;
    #1;
    check_val("mid_busy", busy, 0);
    check_val("mid_valid", ser_valid, 0);
    check_val("mid_last", ser_last, 0);
    check_val("mid_count", frame_count, 0);
    tick();
    check_val("mid_idle_last", ser_last, 0);
    send_frame(8'h96, -1, 0);
    check_val("mid_after_count", frame_count, 1);

    // 2-bit frame counter wraps: 1,2,3,0,1
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    words   = '{8'h12, 8'h80, 8'hC3, 8'h6E, 8'h01};
    cnt_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    for (int f = 0; f < 5; f++) begin
      send_frame(words[f], -1, 0);
      check_val("wrap_count", frame_count2, cnt_exp[f]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
